// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle layout and small helpers for the MIPS pipeline controller.
// Multiply/divide encodings take effect only when MULTDIV_EN is defined.
package ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HIGH = 2'd2;

  // md_op is only meaningful together with md_start, hilo_rd or the md-class flag
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  typedef struct packed {
    logic [1:0] ext_op;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
    logic       j;
    logic       jal;
    logic       jr;
    logic [2:0] md_op;
    logic       md_start;
    logic       hilo_rd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [2:0] md_op_of(input logic [5:0] fn);
    case (fn)
      FN_MULT:  return MD_MULT;
      FN_MULTU: return MD_MULTU;
      FN_DIV:   return MD_DIV;
      FN_DIVU:  return MD_DIVU;
      FN_MFHI:  return MD_MFHI;
      FN_MFLO:  return MD_MFLO;
      FN_MTHI:  return MD_MTHI;
      default:  return MD_MTLO;
    endcase
  endfunction

  function automatic logic [4:0] dest_reg(input ctrl_t c, input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (!c.reg_write)   return 5'd0;
    else if (c.jal)     return 5'd31;
    else if (c.reg_dst) return rd;
    else                return rt;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: control bundle plus rs/rt usage and md-class flags.
// Multiply/divide instructions decode only when MULTDIV_EN is defined; otherwise they are nops.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [4:0]        shamt,
  input  logic [5:0]        fn,
  output logic [CTRL_W-1:0] ctrl,
  output logic              rs_used,
  output logic              rt_used,
  output logic              md_class
);

  ctrl_t c;

  always_comb begin
    c        = '0;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    md_class = 1'b0;
    case (op)
      OP_SPECIAL: begin
        // R-type encodings with a nonzero shift amount are treated as unknown
        if (shamt == 5'd0) begin
          case (fn)
            FN_ADDU: begin
              c.alu_op = ALU_ADD; c.reg_dst = 1'b1; c.reg_write = 1'b1;
              rs_used = 1'b1; rt_used = 1'b1;
            end
            FN_SUBU: begin
              c.alu_op = ALU_SUB; c.reg_dst = 1'b1; c.reg_write = 1'b1;
              rs_used = 1'b1; rt_used = 1'b1;
            end
            FN_JR: begin
              c.jr = 1'b1; rs_used = 1'b1;
            end
`ifdef MULTDIV_EN
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              c.md_start = 1'b1; c.md_op = md_op_of(fn);
              rs_used = 1'b1; rt_used = 1'b1; md_class = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              c.hilo_rd = 1'b1; c.reg_dst = 1'b1; c.reg_write = 1'b1;
              c.md_op = md_op_of(fn); md_class = 1'b1;
            end
            FN_MTHI, FN_MTLO: begin
              c.md_op = md_op_of(fn); rs_used = 1'b1; md_class = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      OP_ORI: begin
        c.ext_op = EXT_ZERO; c.alu_op = ALU_OR; c.alu_src = 1'b1; c.reg_write = 1'b1;
        rs_used = 1'b1;
      end
      OP_LUI: begin
        c.ext_op = EXT_HIGH; c.alu_op = ALU_LUI; c.alu_src = 1'b1; c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.ext_op = EXT_SIGN; c.alu_op = ALU_ADD; c.alu_src = 1'b1;
        c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
        rs_used = 1'b1;
      end
      OP_SW: begin
        c.ext_op = EXT_SIGN; c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_write = 1'b1;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      OP_BEQ: begin
        c.ext_op = EXT_SIGN; c.alu_op = ALU_SUB; c.branch = 1'b1;
        rs_used = 1'b1; rt_used = 1'b1;
      end
      OP_J:   c.j = 1'b1;
      OP_JAL: begin
        c.jal = 1'b1; c.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main controller: D-stage decode, E/M/W control and destination pipeline, D-stage stall.
// Define MULTDIV_EN to add the mult/div instruction set and the multiply/divide busy counter.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CTRL_W-1:0] ctrl_m,
  output logic [CTRL_W-1:0] ctrl_w,
  output logic [4:0]        dst_e,
  output logic [4:0]        dst_m,
  output logic [4:0]        dst_w,
  output logic [CTRL_W-1:0] ctrl_d,
  output logic              stall_d,
  output logic              md_busy
);

  logic [CTRL_W-1:0] dec_raw;
  ctrl_t             dec_p0, ctrl_p1, ctrl_p2, ctrl_p3;
  logic [4:0]        dst_p0, dst_p1, dst_p2, dst_p3;
  logic [4:0]        rs_p0, rt_p0, rd_p0;
  logic              rs_used_p0, rt_used_p0, md_class_p0;
  logic              hit_e, hit_m, is_br_p0;
  logic              load_use, br_e, br_m, md_stall;

  // D stage: decode and hazard detection
  ctrl_decode u_decode (
    .op       (instr_d[31:26]),
    .shamt    (instr_d[10:6]),
    .fn       (instr_d[5:0]),
    .ctrl     (dec_raw),
    .rs_used  (rs_used_p0),
    .rt_used  (rt_used_p0),
    .md_class (md_class_p0)
  );

  assign dec_p0 = dec_raw;
  assign rs_p0  = instr_d[25:21];
  assign rt_p0  = instr_d[20:16];
  assign rd_p0  = instr_d[15:11];
  assign dst_p0 = dest_reg(dec_p0, rt_p0, rd_p0);

  // Register 0 is never a true dependency
  assign hit_e = (rs_used_p0 && rs_p0 != 5'd0 && rs_p0 == dst_p1) ||
                 (rt_used_p0 && rt_p0 != 5'd0 && rt_p0 == dst_p1);
  assign hit_m = (rs_used_p0 && rs_p0 != 5'd0 && rs_p0 == dst_p2) ||
                 (rt_used_p0 && rt_p0 != 5'd0 && rt_p0 == dst_p2);

  assign is_br_p0 = dec_p0.branch | dec_p0.jr;
  assign load_use = ctrl_p1.mem_to_reg && hit_e;
  assign br_e     = is_br_p0 && ctrl_p1.reg_write && hit_e;
  assign br_m     = is_br_p0 && ctrl_p2.mem_to_reg && hit_m;
  assign md_stall = md_class_p0 && md_busy;
  assign stall_d  = load_use | br_e | br_m | md_stall;

`ifdef MULTDIV_EN
  logic [CNT_W-1:0] md_cnt;

  // A stalled md instruction never reaches E while busy, so the load never hits a live count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (ctrl_p1.md_start) begin
      md_cnt <= (ctrl_p1.md_op == MD_DIV || ctrl_p1.md_op == MD_DIVU) ?
                CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy = (md_cnt != '0) || ctrl_p1.md_start;
`else
  assign md_busy = 1'b0;
`endif

  // D->E (bubble on stall), E->M, M->W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p1 <= '0;
      ctrl_p2 <= '0;
      ctrl_p3 <= '0;
      dst_p1  <= '0;
      dst_p2  <= '0;
      dst_p3  <= '0;
    end else begin
      ctrl_p1 <= stall_d ? '0 : dec_p0;
      dst_p1  <= stall_d ? 5'd0 : dst_p0;
      ctrl_p2 <= ctrl_p1;
      dst_p2  <= dst_p1;
      ctrl_p3 <= ctrl_p2;
      dst_p3  <= dst_p2;
    end
  end

  assign ctrl_d = dec_p0;
  assign ctrl_e = ctrl_p1;
  assign ctrl_m = ctrl_p2;
  assign ctrl_w = ctrl_p3;
  assign dst_e  = dst_p1;
  assign dst_m  = dst_p2;
  assign dst_w  = dst_p3;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table plus hazard, reset and multiply/divide sequences.
// The md sequence follows MULTDIV_EN the same way the design does.
module tb_pipe_ctrl_unit;
  import ctrl_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic              clk;
  logic              rst_n;
  logic [31:0]       instr_d;
  logic [CTRL_W-1:0] ctrl_e, ctrl_m, ctrl_w, ctrl_d;
  logic [4:0]        dst_e, dst_m, dst_w;
  logic              stall_d, md_busy;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d),
    .ctrl_e(ctrl_e), .ctrl_m(ctrl_m), .ctrl_w(ctrl_w),
    .dst_e(dst_e), .dst_m(dst_m), .dst_w(dst_w),
    .ctrl_d(ctrl_d), .stall_d(stall_d), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] instr;
    ctrl_t       ctrl;
    logic [4:0]  dst;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic ctrl_t mk(input logic [1:0] ext, input logic m2r, input logic mw,
                               input logic br, input logic [2:0] alu, input logic asrc,
                               input logic rdst, input logic rw, input logic jj,
                               input logic jl, input logic jrr);
    ctrl_t c;
    c = '0;
    c.ext_op = ext; c.mem_to_reg = m2r; c.mem_write = mw; c.branch = br;
    c.alu_op = alu; c.alu_src = asrc; c.reg_dst = rdst; c.reg_write = rw;
    c.j = jj; c.jal = jl; c.jr = jrr;
    return c;
  endfunction

  task automatic step(input logic [31:0] ins, input logic exp_stall, input string nm);
    instr_d = ins;
    @(negedge clk);
    chk(nm, 32'(stall_d), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ctrl_e"}, 32'(ctrl_e), 32'd0);
    chk({nm, " ctrl_m"}, 32'(ctrl_m), 32'd0);
    chk({nm, " ctrl_w"}, 32'(ctrl_w), 32'd0);
    chk({nm, " dst_e"}, 32'(dst_e), 32'd0);
    chk({nm, " dst_m"}, 32'(dst_m), 32'd0);
    chk({nm, " dst_w"}, 32'(dst_w), 32'd0);
    chk({nm, " stall_d"}, 32'(stall_d), 32'd0);
    chk({nm, " md_busy"}, 32'(md_busy), 32'd0);
  endtask

  ctrl_t c_addu, c_beq, ce;
  logic [31:0] i_addu652, i_beq40, i_div, i_mflo;
  int  nstall, nbusy;
  logic done;

  initial begin
    c_addu = mk(EXT_ZERO, 0, 0, 0, ALU_ADD, 0, 1, 1, 0, 0, 0);
    c_beq  = mk(EXT_SIGN, 0, 0, 1, ALU_SUB, 0, 0, 0, 0, 0, 0);
    i_addu652 = rtype(5'd5, 5'd2, 5'd6, 6'h21);
    i_beq40   = itype(6'h04, 5'd4, 5'd0, 16'h0003);
    i_div     = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    i_mflo    = rtype(5'd0, 5'd0, 5'd9, 6'h12);

    tbl[0]  = '{rtype(5'd1, 5'd2, 5'd3, 6'h21), c_addu, 5'd3};
    tbl[1]  = '{rtype(5'd5, 5'd6, 5'd7, 6'h23),
                mk(EXT_ZERO, 0, 0, 0, ALU_SUB, 0, 1, 1, 0, 0, 0), 5'd7};
    tbl[2]  = '{itype(6'h0d, 5'd9, 5'd8, 16'h1234),
                mk(EXT_ZERO, 0, 0, 0, ALU_OR, 1, 0, 1, 0, 0, 0), 5'd8};
    tbl[3]  = '{itype(6'h0f, 5'd0, 5'd10, 16'habcd),
                mk(EXT_HIGH, 0, 0, 0, ALU_LUI, 1, 0, 1, 0, 0, 0), 5'd10};
    tbl[4]  = '{itype(6'h23, 5'd12, 5'd11, 16'h0004),
                mk(EXT_SIGN, 1, 0, 0, ALU_ADD, 1, 0, 1, 0, 0, 0), 5'd11};
    tbl[5]  = '{itype(6'h2b, 5'd14, 5'd13, 16'h0008),
                mk(EXT_SIGN, 0, 1, 0, ALU_ADD, 1, 0, 0, 0, 0, 0), 5'd0};
    tbl[6]  = '{itype(6'h04, 5'd15, 5'd16, 16'hfffe), c_beq, 5'd0};
    tbl[7]  = '{{6'h02, 26'h0000100}, mk(2'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0), 5'd0};
    tbl[8]  = '{{6'h03, 26'h0000200}, mk(2'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 1, 0), 5'd31};
    tbl[9]  = '{rtype(5'd17, 5'd0, 5'd0, 6'h08),
                mk(2'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1), 5'd0};
    tbl[10] = '{{6'h3f, 26'h3ffffff}, '0, 5'd0};
    tbl[11] = '{32'h0000_0000, '0, 5'd0};

    rst_n   = 1'b0;
    instr_d = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Decode table: D result now, E result after one edge, W result two entries later
    for (int i = 0; i < 12; i++) begin
      instr_d = tbl[i].instr;
      @(negedge clk);
      chk($sformatf("tbl%0d ctrl_d", i), 32'(ctrl_d), 32'(tbl[i].ctrl));
      chk($sformatf("tbl%0d stall_d", i), 32'(stall_d), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d ctrl_e", i), 32'(ctrl_e), 32'(tbl[i].ctrl));
      chk($sformatf("tbl%0d dst_e", i), 32'(dst_e), 32'(tbl[i].dst));
      if (i >= 2) begin
        chk($sformatf("tbl%0d ctrl_w", i), 32'(ctrl_w), 32'(tbl[i-2].ctrl));
        chk($sformatf("tbl%0d dst_w", i), 32'(dst_w), 32'(tbl[i-2].dst));
      end
    end

    // Load-use: one stall, one bubble, then the consumer proceeds
    step(itype(6'h23, 5'd1, 5'd5, 16'h0), 1'b0, "lu lw");
    step(i_addu652, 1'b1, "lu stall");
    chk("lu bubble ctrl_e", 32'(ctrl_e), 32'd0);
    chk("lu bubble dst_e", 32'(dst_e), 32'd0);
    step(i_addu652, 1'b0, "lu resume");
    chk("lu addu ctrl_e", 32'(ctrl_e), 32'(c_addu));
    chk("lu addu dst_e", 32'(dst_e), 32'd6);

    // ALU result feeding a branch: one stall
    step(rtype(5'd1, 5'd2, 5'd4, 6'h21), 1'b0, "ab addu");
    step(i_beq40, 1'b1, "ab stall");
    chk("ab bubble ctrl_e", 32'(ctrl_e), 32'd0);
    step(i_beq40, 1'b0, "ab resume");
    chk("ab beq ctrl_e", 32'(ctrl_e), 32'(c_beq));

    // Load feeding a branch: two stalls (E then M)
    step(itype(6'h23, 5'd1, 5'd4, 16'h0), 1'b0, "lb lw");
    step(i_beq40, 1'b1, "lb stall1");
    step(i_beq40, 1'b1, "lb stall2");
    step(i_beq40, 1'b0, "lb resume");
    chk("lb beq ctrl_e", 32'(ctrl_e), 32'(c_beq));

    // Writes to $0 and unused rt fields never stall
    step(itype(6'h23, 5'd1, 5'd0, 16'h0), 1'b0, "z0 lw");
    step(rtype(5'd0, 5'd0, 5'd6, 6'h21), 1'b0, "z0 addu");
    step(itype(6'h23, 5'd1, 5'd8, 16'h0), 1'b0, "rt lw");
    step(itype(6'h0d, 5'd20, 5'd8, 16'h0001), 1'b0, "rt ori");

    // Reset in the middle of a load-use stall
    step(itype(6'h23, 5'd1, 5'd5, 16'h0), 1'b0, "mr lw");
    instr_d = i_addu652;
    @(negedge clk);
    chk("mr stall before", 32'(stall_d), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mr async");
    @(posedge clk);
    #1;
    chk("mr held ctrl_e", 32'(ctrl_e), 32'd0);
    rst_n   = 1'b1;
    instr_d = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    @(negedge clk);
    chk("mr first stall", 32'(stall_d), 32'd0);
    @(posedge clk);
    #1;
    chk("mr addu ctrl_e", 32'(ctrl_e), 32'(c_addu));
    chk("mr addu dst_e", 32'(dst_e), 32'd3);

`ifdef MULTDIV_EN
    // div then mflo: mflo waits out the whole busy window
    step(i_div, 1'b0, "md div");
    nstall = 0;
    nbusy  = 0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      instr_d = i_mflo;
      @(negedge clk);
      if (stall_d) begin
        nstall++;
        if (md_busy) nbusy++;
      end else begin
        done = 1'b1;
        chk("md busy at release", 32'(md_busy), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    chk("md released", 32'(done), 32'd1);
    chk("md stall cycles", 32'(nstall), 32'(DIV_C + 1));
    chk("md busy cycles", 32'(nbusy), 32'(DIV_C + 1));
    ce = ctrl_e;
    chk("md mflo hilo_rd", 32'(ce.hilo_rd), 32'd1);
    chk("md mflo dst_e", 32'(dst_e), 32'd9);
`else
    instr_d = i_div;
    @(negedge clk);
    chk("nomd div ctrl_d", 32'(ctrl_d), 32'd0);
    chk("nomd div stall", 32'(stall_d), 32'd0);
    @(posedge clk);
    #1;
    instr_d = i_mflo;
    @(negedge clk);
    chk("nomd mflo ctrl_d", 32'(ctrl_d), 32'd0);
    chk("nomd mflo stall", 32'(stall_d), 32'd0);
    chk("nomd md_busy", 32'(md_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("nomd mflo dst_e", 32'(dst_e), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
